// File: rtl/vcache_dma_arbiter.sv
// Round-robin arbiter sharing one memory DMA channel among vcache DMA ports.
// Holds the grant from packet acceptance through the last data beat.
module vcache_dma_arbiter #(
  parameter int num_caches_p          = 4,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  localparam int dma_pkt_width_lp     = addr_width_p + 1,
  localparam int id_width_lp          =
    (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
  input  logic                                     clk_i,
  input  logic                                     reset_n_i,
  input  logic [num_caches_p*dma_pkt_width_lp-1:0] cache_dma_pkt_i,
  input  logic [num_caches_p-1:0]                  cache_dma_pkt_v_i,
  output logic [num_caches_p-1:0]                  cache_dma_pkt_yumi_o,
  output logic [data_width_p-1:0]                  cache_dma_data_o,
  output logic [num_caches_p-1:0]                  cache_dma_data_v_o,
  input  logic [num_caches_p-1:0]                  cache_dma_data_ready_i,
  input  logic [num_caches_p*data_width_p-1:0]     cache_dma_data_i,
  input  logic [num_caches_p-1:0]                  cache_dma_data_v_i,
  output logic [num_caches_p-1:0]                  cache_dma_data_yumi_o,
  output logic [dma_pkt_width_lp-1:0]              mem_dma_pkt_o,
  output logic                                     mem_dma_pkt_v_o,
  input  logic                                     mem_dma_pkt_yumi_i,
  input  logic [data_width_p-1:0]                  mem_dma_data_i,
  input  logic                                     mem_dma_data_v_i,
  output logic                                     mem_dma_data_ready_o,
  output logic [data_width_p-1:0]                  mem_dma_data_o,
  output logic                                     mem_dma_data_v_o,
  input  logic                                     mem_dma_data_yumi_i,
  output logic                                     busy_o,
  output logic [id_width_lp-1:0]                   grant_id_o
);

  localparam int CW = $clog2(block_size_in_words_p + 1);
  localparam logic [CW-1:0] LAST = CW'(block_size_in_words_p - 1);
  localparam logic [id_width_lp-1:0] MAX_ID =
    id_width_lp'(num_caches_p - 1);

  typedef enum logic [1:0] {
    IDLE, PKT, READ_DATA, WRITE_DATA
  } state_e;

  state_e                 state_q, state_d;
  logic [id_width_lp-1:0] grant_q, grant_d;
  logic [id_width_lp-1:0] rr_q, rr_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [dma_pkt_width_lp-1:0] pkt_a  [num_caches_p];
  logic [data_width_p-1:0]     data_a [num_caches_p];

  for (genvar g = 0; g < num_caches_p; g++) begin : g_split
    assign pkt_a[g] =
      cache_dma_pkt_i[g*dma_pkt_width_lp +: dma_pkt_width_lp];
    assign data_a[g] =
      cache_dma_data_i[g*data_width_p +: data_width_p];
  end

  logic [id_width_lp-1:0] pick;
  logic                   found;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < num_caches_p; i++) begin
      if (!found &&
          cache_dma_pkt_v_i[id_width_lp'((int'(rr_q) + i) % num_caches_p)]) begin
        found = 1'b1;
        pick  = id_width_lp'((int'(rr_q) + i) % num_caches_p);
      end
    end
  end

  logic beat;

  always_comb begin
    state_d               = state_q;
    grant_d               = grant_q;
    rr_d                  = rr_q;
    cnt_d                 = cnt_q;
    beat                  = 1'b0;
    cache_dma_pkt_yumi_o  = '0;
    cache_dma_data_v_o    = '0;
    cache_dma_data_yumi_o = '0;
    cache_dma_data_o      = mem_dma_data_i;
    mem_dma_pkt_o         = '0;
    mem_dma_pkt_v_o       = 1'b0;
    mem_dma_data_ready_o  = 1'b0;
    mem_dma_data_o        = '0;
    mem_dma_data_v_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = PKT;
        end
      end
      PKT: begin
        mem_dma_pkt_o                 = pkt_a[grant_q];
        mem_dma_pkt_v_o               = 1'b1;
        cache_dma_pkt_yumi_o[grant_q] = mem_dma_pkt_yumi_i;
        if (mem_dma_pkt_yumi_i) begin
          cnt_d   = '0;
          state_d = pkt_a[grant_q][addr_width_p] ? WRITE_DATA : READ_DATA;
        end
      end
      READ_DATA: begin
        mem_dma_data_ready_o        = cache_dma_data_ready_i[grant_q];
        cache_dma_data_v_o[grant_q] = mem_dma_data_v_i;
        beat = mem_dma_data_v_i & cache_dma_data_ready_i[grant_q];
      end
      WRITE_DATA: begin
        mem_dma_data_o                 = data_a[grant_q];
        mem_dma_data_v_o               = cache_dma_data_v_i[grant_q];
        cache_dma_data_yumi_o[grant_q] = mem_dma_data_yumi_i;
        beat = cache_dma_data_v_i[grant_q] & mem_dma_data_yumi_i;
      end
      default: state_d = IDLE;
    endcase
    if (beat) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        rr_d    = (grant_q == MAX_ID) ? '0 : grant_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign grant_id_o = grant_q;

endmodule

// File: doc/vcache_dma_arbiter.md
Name: vcache_dma_arbiter

Overview:
- Shares one DMA memory channel among num_caches_p vcache DMA ports.
- Handles one DMA transaction at a time, choosing requesters round-robin. A transaction is a packet plus block_size_in_words_p data beats.
- Sits between the vcache array's DMA ports and the single memory-side DMA interface. The grant is held until the whole block has transferred.

Parameters:
- num_caches_p, 4, number of vcache requesters (>=2)
- addr_width_p, 32, DMA packet address width
- data_width_p, 32, DMA data beat width
- block_size_in_words_p, 8, beats per transaction (>=1)
- dma_pkt_width_lp, addr_width_p+1, packet width: {write_not_read, addr}
- id_width_lp, `BSG_SAFE_CLOG2(num_caches_p), requester id width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- cache_dma_pkt_i  in  num_caches_p*dma_pkt_width_lp  per-cache packet
- cache_dma_pkt_v_i  in  num_caches_p  per-cache packet valid
- cache_dma_pkt_yumi_o  out  num_caches_p  packet accepted
- cache_dma_data_o  out  data_width_p  fill data, broadcast to all caches
- cache_dma_data_v_o  out  num_caches_p  fill valid, one-hot to the granted cache only
- cache_dma_data_ready_i  in  num_caches_p  cache can take fill beat
- cache_dma_data_i  in  num_caches_p*data_width_p  evict data
- cache_dma_data_v_i  in  num_caches_p  evict data valid
- cache_dma_data_yumi_o  out  num_caches_p  evict beat accepted
- mem_dma_pkt_o  out  dma_pkt_width_lp  packet to memory
- mem_dma_pkt_v_o  out  1  packet valid
- mem_dma_pkt_yumi_i  in  1  memory accepted packet
- mem_dma_data_i  in  data_width_p  fill data from memory
- mem_dma_data_v_i  in  1  fill valid
- mem_dma_data_ready_o  out  1  arbiter can take fill beat
- mem_dma_data_o  out  data_width_p  evict data to memory
- mem_dma_data_v_o  out  1  evict valid
- mem_dma_data_yumi_i  in  1  memory accepted evict beat
- busy_o  out  1  transaction in progress (state != IDLE)
- grant_id_o  out  id_width_lp  currently granted cache

Behaviour:
- State machine states: IDLE, PKT, READ_DATA, WRITE_DATA.
- Registers: state_r, grant_r, rr_ptr_r, beat_cnt_r (clog2(block_size_in_words_p+1) bits).
- Reset (reset_n_i low, asynchronous):
  - state_r=IDLE, grant_r=0, rr_ptr_r=0, beat_cnt_r=0.
  - All valid, yumi and ready outputs are 0; busy_o=0; grant_id_o=0.
- IDLE:
  - If any cache_dma_pkt_v_i is set, grant_r <= first set index searching from rr_ptr_r upward, wrapping at num_caches_p; go to PKT.
  - No outputs are asserted in IDLE. A request therefore waits at least one cycle before it is presented to memory.
- PKT:
  - mem_dma_pkt_o = packet of grant_r; mem_dma_pkt_v_o=1.
  - cache_dma_pkt_yumi_o[grant_r] = mem_dma_pkt_yumi_i, the same cycle.
  - On yumi: beat_cnt_r <= 0; go to WRITE_DATA if write_not_read, else READ_DATA.
  - The granted cache holds its valid; other caches' requests do not change grant_r.
- READ_DATA:
  - mem_dma_data_ready_o = cache_dma_data_ready_i[grant_r].
  - cache_dma_data_v_o = one-hot(grant_r) & mem_dma_data_v_i.
  - cache_dma_data_o = mem_dma_data_i.
  - A beat transfers when mem_dma_data_v_i & ready; it increments beat_cnt_r.
- WRITE_DATA:
  - mem_dma_data_o = cache_dma_data_i[grant_r].
  - mem_dma_data_v_o = cache_dma_data_v_i[grant_r].
  - cache_dma_data_yumi_o[grant_r] = mem_dma_data_yumi_i.
  - A beat transfers on v & yumi; it increments beat_cnt_r.
- Completion:
  - On the beat where beat_cnt_r == block_size_in_words_p-1: go to IDLE and set rr_ptr_r <= grant_r+1, wrapping to 0 after num_caches_p-1.
  - Back-to-back transactions therefore have exactly one IDLE cycle between them.
- Non-granted caches never see valid, yumi or ready asserted.
- Valid or ready signals from non-granted caches are ignored.
- Reset asserted mid-transaction: the arbiter returns to IDLE immediately, the partial block is dropped, and no further beats are forwarded.
- Simultaneous requests from all caches: served strictly in rotation, each waiting at most num_caches_p-1 transactions.

Test Plan:
- Single read, cache 2, addr 0x1000, block 8: mem_dma_pkt_o={0,0x1000} one cycle after request; 8 fill beats reach cache 2 only; busy_o falls after beat 8; rr_ptr becomes 3.
- Simultaneous requests from caches 0-3 after reset: grants issue in order 0,1,2,3, then 0 again on re-request; each block completes before the next pkt_v.
- Write from cache 1 with memory yumi toggling every other cycle: exactly 8 evict beats reach memory in order; cache_dma_data_yumi_o[1] matches mem yumi each cycle; others stay 0.
- Read with cache ready held low for beats 3-5: mem_dma_data_ready_o stays low over the same cycles; no beat is lost or duplicated; beat count reaches 8.
- rr_ptr=3 with requests from caches 0 and 3: cache 3 is granted first, then 0; the pointer wraps to 0 after cache 3 completes.
- reset_n_i pulsed low during beat 4 of a read: outputs clear asynchronously; state IDLE, busy_o=0; a new request is then served normally.
